// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF = 3;
    localparam int NRD_DEF = 2;

    function automatic logic in_range(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction

    function automatic int popcount(input logic [63:0] v);
        int c = 0;
        for (int i = 0; i < 64; i++) c += int'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port with range check, R0 zero, bypass and valid.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW = AW_DEF,
    parameter int ZERO_R0 = 0
) (
    input  logic [AW-1:0]          addr,
    input  logic                   write,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [DEPTH*WIDTH-1:0] regs,
    input  logic [DEPTH-1:0]       pend,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid
);
    logic in_rng, is_zero, byp;
    int sel;

    always_comb begin
        in_rng = in_range(32'(addr), DEPTH);
        is_zero = ZERO_R0 != 0 && addr == '0;
        byp = write && wr_addr == addr && in_rng && !is_zero;
        // out-of-range addresses index register 0 so the select never runs off the array
        sel = in_rng ? int'(addr) : 0;
        rd_data = (!in_rng || is_zero) ? '0 : byp ? wr_data : regs[sel*WIDTH +: WIDTH];
        rd_valid = !in_rng || is_zero || byp || !pend[sel];
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with per-register pending bits and write bypass.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW = AW_DEF,
    parameter int NRD = NRD_DEF,
    parameter int ZERO_R0 = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write,
    input  logic [AW-1:0]               wrAddr,
    input  logic [WIDTH-1:0]            wrData,
    input  logic                        rsv,
    input  logic [AW-1:0]               rsvAddr,
    input  logic [NRD*AW-1:0]           rdAddr,
    output logic [NRD*WIDTH-1:0]        rdData,
    output logic [NRD-1:0]              rdValid,
    output logic                        anyPending,
    output logic [$clog2(DEPTH+1)-1:0]  pendCount
);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [CW-1:0] pend_cnt_q, pend_cnt_d;
    logic [DEPTH*WIDTH-1:0] regs_flat;
    logic wr_ok, rsv_ok;

    always_comb begin
        wr_ok = write && in_range(32'(wrAddr), DEPTH) && !(ZERO_R0 != 0 && wrAddr == '0);
        rsv_ok = rsv && in_range(32'(rsvAddr), DEPTH) && !(ZERO_R0 != 0 && rsvAddr == '0);
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = (wr_ok && wrAddr == AW'(i)) ? wrData : regs_q[i];
            // a reserve in the same cycle as a write to that register wins: new producer pending
            pend_d[i] = (rsv_ok && rsvAddr == AW'(i)) || (pend_q[i] && !(wr_ok && wrAddr == AW'(i)));
            regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
        end
        pend_cnt_d = CW'(popcount(64'(pend_d)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            pend_q <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pendCount = pend_cnt_q;
    assign anyPending = pend_cnt_q != '0;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_R0(ZERO_R0)) u_rd (
            .addr     (rdAddr[g*AW +: AW]),
            .write    (write),
            .wr_addr  (wrAddr),
            .wr_data  (wrData),
            .regs     (regs_flat),
            .pend     (pend_q),
            .rd_data  (rdData[g*WIDTH +: WIDTH]),
            .rd_valid (rdValid[g])
        );
    end
endmodule
